// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt sequencer between the M stage and CP0
//
// Purpose: synchronises and masks hardware interrupts, arbitrates them
// against synchronous M-stage exceptions and eret, and drives CP0 EXL
// set/clear strobes, Cause/EPC write data, pipeline flush and PC redirect.
//
// Optional feature: define HWINT_SYNC_EN to insert a 2-flop synchroniser
// on hw_int (hw_int->exl_set latency 3 cycles instead of 1).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   hw_int[5:0]         hardware interrupt lines
//   sr[31:0], epc[31:0] CP0 status and EPC values
//   m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_eret
//                       M-stage instruction information
//   exl_set, exl_clr    one-cycle CP0 strobes
//   exc_code, cause_ip, cause_bd, epc_o
//                       Cause/EPC write data, valid with exl_set
//   flush, redirect, redirect_pc
//                       pipeline kill and PC redirect
//   busy                sequencer not idle
module exc_ctrl #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic [31:0] sr,
  input  logic [31:0] epc,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic        m_exc_valid,
  input  logic [4:0]  m_exc_code,
  input  logic        m_eret,
  output logic        exl_set,
  output logic        exl_clr,
  output logic [4:0]  exc_code,
  output logic [5:0]  cause_ip,
  output logic        cause_bd,
  output logic [31:0] epc_o,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAKE,
    S_RET,
    S_DRAIN
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  state_t      state, state_next;
  logic [2:0]  drain_cnt;
  logic [5:0]  ip_sync;
  logic [5:0]  pending;
  logic        int_req;
  logic        take_exc;
  logic        take_ret;
  logic        capture;
  logic        unused_sr;

  assign unused_sr = ^{sr[31:16], sr[9:2]};

`ifdef HWINT_SYNC_EN
  logic [5:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= hw_int;
      sync2 <= sync1;
    end
  end

  assign ip_sync = sync2;
`else
  assign ip_sync = hw_int;
`endif

  assign pending  = ip_sync & sr[15:10];
  assign int_req  = (|pending) & sr[0] & ~sr[1] & m_valid;
  assign take_exc = m_valid & m_exc_valid;
  assign take_ret = m_valid & m_eret & sr[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are masked while rst is high so a TAKE/RET cycle that coincides
  // with reset never reaches CP0.
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    unique case (state)
      S_IDLE: begin
        if (int_req || take_exc) begin
          state_next = S_TAKE;
          capture    = 1'b1;
        end else if (take_ret) begin
          state_next = S_RET;
        end
      end
      S_TAKE: begin
        exl_set    = ~rst;
        redirect   = ~rst;
        state_next = S_DRAIN;
        if (!rst) redirect_pc = VECTOR_ADDR;
      end
      S_RET: begin
        exl_clr    = ~rst;
        redirect   = ~rst;
        state_next = S_DRAIN;
        if (!rst) redirect_pc = epc;
      end
      S_DRAIN: begin
        if (drain_cnt == 3'd0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign flush = (state != S_IDLE);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == S_TAKE || state == S_RET) begin
      drain_cnt <= CNT_INIT;
    end else if (state == S_DRAIN && drain_cnt != 3'd0) begin
      drain_cnt <= drain_cnt - 3'd1;
    end
  end

  // Cause/EPC data is captured only on exception entry; it holds through
  // eret so CP0 always sees the data of the last exl_set.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_code <= '0;
      cause_ip <= '0;
      cause_bd <= 1'b0;
      epc_o    <= '0;
    end else if (capture) begin
      exc_code <= int_req ? 5'd0 : m_exc_code;
      cause_ip <= pending;
      cause_bd <= m_bd;
      epc_o    <= m_bd ? (m_pc - 32'd4) : m_pc;
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer that sits between the pipeline's memory (M) stage and the CP0 register file. It synchronises and masks hardware interrupt lines, arbitrates them against synchronous exceptions reported by M, and drives CP0's EXL set/clear, cause and EPC write strobes. It also drives pipeline flush and PC redirect for exception entry and `eret` return.

## Interface
Parameters:
- VECTOR_ADDR, 32'h0000_4180, handler entry PC
- DRAIN_CYCLES, 2, flush cycles after redirect (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- hw_int  in  6  asynchronous hardware interrupt lines
- sr  in  32  CP0 status: [15:10] IM, [1] EXL, [0] IE
- epc  in  32  CP0 EPC value
- m_valid  in  1  M stage holds a real instruction
- m_pc  in  32  PC of M instruction
- m_bd  in  1  M instruction is in a branch delay slot
- m_exc_valid  in  1  M instruction raised a synchronous exception
- m_exc_code  in  5  its ExcCode (never 0)
- m_eret  in  1  M instruction is `eret`
- exl_set  out  1  one-cycle pulse: CP0 sets EXL, writes EPC/Cause
- exl_clr  out  1  one-cycle pulse: CP0 clears EXL
- exc_code  out  5  ExcCode for Cause[6:2], valid with exl_set
- cause_ip  out  6  pending-interrupt snapshot for Cause[15:10], valid with exl_set
- cause_bd  out  1  Cause.BD, valid with exl_set
- epc_o  out  32  value written to EPC, valid with exl_set
- flush  out  1  kill all pipeline stages up to and including M
- redirect  out  1  load redirect_pc into PC
- redirect_pc  out  32  target PC
- busy  out  1  state != IDLE

## Operation
- Interrupt path:
  - ip_sync = hw_int after the synchroniser (see Configuration).
  - pending = ip_sync & sr[15:10].
  - int_req = |pending & sr[0] & ~sr[1] & m_valid.
- States: IDLE, TAKE, RET, DRAIN.
- IDLE priority, evaluated every cycle:
  - int_req → TAKE, with exc_code=0 and cause_ip=pending.
  - else m_valid & m_exc_valid → TAKE, with exc_code=m_exc_code and cause_ip=pending.
  - else m_valid & m_eret & sr[1] → RET.
  - else stay in IDLE.
  - `eret` with EXL=0 is a no-op.
- EPC rule: epc_o = m_bd ? m_pc − 4 : m_pc (32-bit wrap). cause_bd = m_bd.
- TAKE (1 cycle):
  - exl_set=1, flush=1, redirect=1, redirect_pc=VECTOR_ADDR.
  - Then DRAIN.
- RET (1 cycle):
  - exl_clr=1, flush=1, redirect=1, redirect_pc=epc. epc is sampled in the RET cycle.
  - Then DRAIN.
- DRAIN:
  - flush=1; counter counts from DRAIN_CYCLES−1 down to 0, then IDLE.
  - All inputs are ignored in TAKE, RET and DRAIN.
- exc_code, cause_ip, cause_bd and epc_o are registered at the IDLE decision and hold until the next decision.
- Reset mid-operation: rst returns to IDLE immediately. No pulse is emitted in the rst cycle or the following cycle.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including exc_code, cause_ip, cause_bd, epc_o, redirect_pc.
  - Synchroniser flops 0, drain counter 0.
- Decision is sampled at edge N; exl_set/exl_clr/redirect pulse in cycle N+1.
- flush is high for 1+DRAIN_CYCLES consecutive cycles. busy is high for the same cycles.
- Earliest next decision is at cycle N+2+DRAIN_CYCLES.
- exl_set and exl_clr are never high together. redirect is high exactly when exl_set|exl_clr.
- Simultaneous events:
  - interrupt + exception: interrupt wins, exc_code=0.
  - exception + eret on the same M instruction: exception wins.
  - hw_int asserted while busy: stays pending and is taken at the first IDLE cycle where int_req holds.

## Configuration
- HWINT_SYNC_EN defined:
  - ip_sync passes through a 2-flop synchroniser.
  - hw_int→exl_set latency = 3 cycles, given an IDLE state with m_valid and unmasked.
- Not defined:
  - ip_sync = hw_int combinationally; latency = 1 cycle.
  - hw_int must then be synchronous to clk.

## Test plan
- sr=0x0000_0401, hw_int[0] rises, m_pc=0x3010, m_bd=0 → exl_set pulse, exc_code=0, cause_ip=6'b000001, epc_o=0x3010, redirect_pc=0x4180, flush 3 cycles.
- m_exc_valid=1, code=12, m_pc=0x3024, m_bd=1, sr=0 → exc_code=12, cause_bd=1, epc_o=0x3020, no interrupt influence.
- sr=0x0000_0403, hw_int[0]=1 → no exl_set while EXL=1.
- Clear EXL, issue m_eret with epc=0x3020 → exl_clr pulse, redirect_pc=0x3020.
- hw_int[1] and m_exc_valid(code=4) in same cycle, IM[1]=1, IE=1 → exc_code=0, cause_ip=6'b000010.
- Assert rst during DRAIN → flush=0 and busy=0 the next cycle.
- New exception during DRAIN → ignored.
- Build with and without HWINT_SYNC_EN → measured hw_int→exl_set latency is 3 and 1 cycles respectively.
